// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants, FSM state type and matrix element indexing for the matmul scheduler
package matmul_pkg;
  localparam int ELEM_W  = 16;
  localparam int MAT_DIM = 4;
  localparam int DATA_W  = MAT_DIM * MAT_DIM * ELEM_W;
  typedef enum logic [2:0] {INIT, IDLE, LOAD_B, WAIT, RESP} state_e;
  function automatic int unsigned elem_idx(input int unsigned row, input int unsigned col);
    return row * MAT_DIM + col;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr (mod NREQ)
//   req_i  requests      ptr_i  search start
//   gnt_o  one-hot grant idx_o  encoded grant  any_o  some request present
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);
  logic [IW:0]   s;
  logic [IW-1:0] j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    s     = '0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr_i} + (IW+1)'(k);
      j = (s >= (IW+1)'(NREQ)) ? IW'(s - (IW+1)'(NREQ)) : IW'(s);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end
endmodule

// File: rtl/matmul_scheduler.sv
// matmul_scheduler: shares one 4x4 matrix engine between NREQ requesters, round-robin
//   req_valid/req_a/req_b/req_ready  per-requester operand intake (ready is one-hot, combinational)
//   rsp_valid/rsp_ready/rsp_data/rsp_id  result channel with owning requester index
//   eng_bus/eng_stb/eng_clr/eng_result   engine operand bus, phase strobe, clear and product
//   busy  operation in flight          done_cnt  completed responses (wraps)
module matmul_scheduler
  import matmul_pkg::*;
#(
  parameter int  NREQ     = 2,
  parameter int  CALC_LAT = 4,
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW       = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [IW-1:0]          rsp_id,
  output logic [DATA_W-1:0]      eng_bus,
  output logic                   eng_stb,
  output logic                   eng_clr,
  input  logic [DATA_W-1:0]      eng_result,
  output logic                   busy,
  output logic [15:0]            done_cnt
);
  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, id_q, rsp_id_q, g;
  logic [DATA_W-1:0] b_q, eng_bus_q, rsp_data_q;
  logic [CW-1:0]     cnt_q;
  logic              eng_stb_q, rsp_valid_q, any, accept;
  logic [15:0]       done_cnt_q;
  logic [NREQ-1:0]   gnt;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i(req_valid),
    .ptr_i(rr_ptr_q),
    .gnt_o(gnt),
    .idx_o(g),
    .any_o(any)
  );
  assign accept = state_q == IDLE && any;
  always_ff @(posedge clk) state_q <= rst ? INIT : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = IDLE;
      IDLE:    state_d = any ? LOAD_B : IDLE;
      LOAD_B:  state_d = WAIT;
      WAIT:    state_d = (cnt_q == '0) ? RESP : WAIT;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = INIT;
    endcase
  end
  always_comb begin
    req_ready = (!rst && state_q == IDLE) ? gnt : '0;
    busy      = !rst && state_q inside {LOAD_B, WAIT, RESP};
    eng_clr   = rst || state_q == INIT;
  end
  // A goes straight onto the bus at accept; only B needs holding for the second phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      id_q        <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      eng_bus_q   <= '0;
      eng_stb_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      done_cnt_q  <= '0;
    end else begin
      eng_stb_q <= accept || state_q == LOAD_B;
      if (accept) begin
        b_q       <= req_b[g * DATA_W +: DATA_W];
        id_q      <= g;
        eng_bus_q <= req_a[g * DATA_W +: DATA_W];
      end
      if (state_q == LOAD_B) begin
        eng_bus_q <= b_q;
        cnt_q     <= CW'(CALC_LAT - 1);
      end
      if (state_q == WAIT) cnt_q <= cnt_q - CW'(1);
      if (state_q == WAIT && cnt_q == '0) begin
        rsp_data_q  <= eng_result;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end
      if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
        rr_ptr_q    <= (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);
        done_cnt_q  <= done_cnt_q + 16'd1;
      end
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign eng_bus   = eng_bus_q;
  assign eng_stb   = eng_stb_q;
  assign done_cnt  = done_cnt_q;
endmodule

// File: tb/tb_matmul_scheduler.sv
// tb_matmul_scheduler: randomized and directed checks of matmul_scheduler against a behavioural model
module tb_matmul_scheduler;
  import matmul_pkg::*;
  localparam int NREQ     = 2;
  localparam int CALC_LAT = 4;
  localparam int DW       = DATA_W;
  logic              clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*DW-1:0] req_a = '0, req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid, rsp_ready = 1'b1;
  logic [DW-1:0]     rsp_data, eng_bus, eng_result = '0;
  logic [0:0]        rsp_id;
  logic              eng_stb, eng_clr, busy;
  logic [15:0]       done_cnt;
  int n_chk = 0, n_fail = 0, cyc = 0;
  matmul_scheduler #(.NREQ(NREQ), .CALC_LAT(CALC_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .eng_bus(eng_bus), .eng_stb(eng_stb),
    .eng_clr(eng_clr), .eng_result(eng_result), .busy(busy), .done_cnt(done_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  // C[r][c] = sum_k A[r][k]*B[k][c], elements row-major, 16-bit wrapping arithmetic
  function automatic logic [DW-1:0] mm(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] c;
    logic [ELEM_W-1:0] s, ae, be;
    c = '0;
    for (int r = 0; r < MAT_DIM; r++)
      for (int col = 0; col < MAT_DIM; col++) begin
        s = '0;
        for (int k = 0; k < MAT_DIM; k++) begin
          ae = a[elem_idx(r, k) * ELEM_W +: ELEM_W];
          be = b[elem_idx(k, col) * ELEM_W +: ELEM_W];
          s  = s + ae * be;
        end
        c[elem_idx(r, col) * ELEM_W +: ELEM_W] = s;
      end
    return c;
  endfunction
  function automatic int win(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction
  // engine model: A then B on successive strobes, product valid only in the cycle before CALC_LAT edges after B
  logic [DW-1:0] ea = '0, prod = '0;
  logic ph = 1'b0;
  int age = -1;
  always @(posedge clk) begin
    if (age >= 0) age++;
    if (eng_clr) begin
      ph  = 1'b0;
      age = -1;
    end else if (eng_stb) begin
      if (!ph) ea = eng_bus;
      else begin
        prod = mm(ea, eng_bus);
        age  = 0;
      end
      ph = ~ph;
    end
    eng_result <= (age == CALC_LAT - 2) ? prod : rnd();
  end
  // scheduler reference model and monitor
  bit init_m = 1, busy_m = 0, rst_prev = 0, spacing_on = 0;
  int ptr_m = 0, acc_cyc = -100, last_acc = -1, stb_n = 0, exp_id = 0, last_id = -1;
  logic [15:0] done_m = '0;
  logic [DW-1:0] exp_a = '0, exp_b = '0, exp_c = '0, last_rsp = '0;
  logic [NREQ-1:0] acc_flag = '0;
  int gq[$];
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    int w, gi;
    if (rst) begin
      check("clr_in_rst", eng_clr, 1);
      if (rst_prev) begin
        check("rsp_valid_rst", rsp_valid, 0);
        check("req_ready_rst", req_ready, 0);
        check("busy_rst", busy, 0);
        check("done_rst", done_cnt, 0);
        check("stb_rst", eng_stb, 0);
        check("bus_rst", eng_bus, 0);
      end
      init_m = 1; busy_m = 0; ptr_m = 0; done_m = '0; last_acc = -1;
    end else begin
      w = win(req_valid, ptr_m);
      exp_rdy = (init_m || busy_m || w < 0) ? '0 : (NREQ'(1) << w);
      check("eng_clr", eng_clr, init_m);
      check("req_ready", req_ready, exp_rdy);
      check("busy", busy, busy_m);
      check("done_cnt", done_cnt, done_m);
      check("eng_stb", eng_stb, busy_m && (cyc == acc_cyc || cyc == acc_cyc + 1));
      if (eng_stb) begin
        check(stb_n == 0 ? "bus_a" : "bus_b", eng_bus, stb_n == 0 ? exp_a : exp_b);
        stb_n++;
      end
      check("rsp_valid", rsp_valid, busy_m && cyc - acc_cyc >= CALC_LAT + 1);
      if (rsp_valid) begin
        check("rsp_data", rsp_data, exp_c);
        check("rsp_id", rsp_id, exp_id);
        if (rsp_ready) begin
          check("stb_pulses", stb_n, 2);
          check("bus_hold", eng_bus, exp_b);
          last_rsp = rsp_data;
          last_id  = int'(rsp_id);
          done_m++;
          ptr_m  = (exp_id + 1) % NREQ;
          busy_m = 0;
        end
      end
      if (|(req_valid & req_ready)) begin
        gi = 0;
        for (int i = NREQ - 1; i >= 0; i--) if (req_valid[i] && req_ready[i]) gi = i;
        if (w < 0) w = gi;
        if (spacing_on && last_acc >= 0) check("spacing", cyc - last_acc, CALC_LAT + 3);
        last_acc = cyc;
        acc_cyc  = cyc + 1;
        exp_id   = w;
        exp_a    = req_a[w*DW +: DW];
        exp_b    = req_b[w*DW +: DW];
        exp_c    = mm(exp_a, exp_b);
        busy_m   = 1;
        stb_n    = 0;
        gq.push_back(gi);
        acc_flag[gi] = 1'b1;
      end
      init_m = 0;
    end
    rst_prev = rst;
  end
  // driver
  logic [NREQ-1:0] keep = '0;
  bit rnd_mode = 0;
  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[i] = 1'b1;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i]  = 1'b0;
        req_valid[i] = 1'b0;
        if (keep[i]) set_req(i, rnd(), rnd());
      end
      if (rnd_mode && !req_valid[i] && $urandom_range(3) == 0) set_req(i, rnd(), rnd());
    end
    if (rnd_mode) rsp_ready = 1'($urandom_range(1));
  endtask
  task automatic wait_idle(input int lim);
    int n = 0;
    while ((busy_m || req_valid != '0) && n < lim) begin
      tick();
      n++;
    end
    check("idle_timeout", n < lim, 1);
  endtask
  logic [DW-1:0] ident, seq, twos;
  int n;
  initial begin
    ident = '0;
    seq   = '0;
    twos  = '0;
    for (int r = 0; r < MAT_DIM; r++)
      for (int c = 0; c < MAT_DIM; c++) begin
        ident[elem_idx(r, c) * ELEM_W +: ELEM_W] = (r == c) ? 16'd1 : 16'd0;
        seq[elem_idx(r, c) * ELEM_W +: ELEM_W]   = 16'(elem_idx(r, c) + 1);
        twos[elem_idx(r, c) * ELEM_W +: ELEM_W]  = 16'd2;
      end
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("idle_busy", busy, 0);
    check("idle_ready", req_ready, 0);
    check("idle_done", done_cnt, 0);
    // single request: identity x (1..16)
    gq.delete();
    set_req(0, ident, seq);
    wait_idle(30);
    check("single_done", done_cnt, 1);
    check("single_data_is_b", last_rsp, seq);
    check("single_id", last_id, 0);
    check("single_grant", gq.size() > 0 ? gq[0] : -1, 0);
    // both requesters continuously valid
    gq.delete();
    last_acc   = -1;
    spacing_on = 1;
    keep       = '1;
    set_req(0, rnd(), rnd());
    set_req(1, rnd(), rnd());
    for (n = 0; n < 100 && gq.size() < 5; n++) tick();
    check("grant_timeout", gq.size() >= 5, 1);
    keep = '0;
    wait_idle(60);
    spacing_on = 0;
    check("rr_start", gq.size() > 0 ? gq[0] : -1, 1);
    for (int k = 1; k < gq.size(); k++) check("rr_alt", gq[k], 1 - gq[k-1]);
    // backpressure with a second requester waiting
    gq.delete();
    rsp_ready = 1'b0;
    set_req(0, rnd(), rnd());
    set_req(1, rnd(), rnd());
    for (n = 0; n < 40 && !rsp_valid; n++) tick();
    check("bp_rsp_timeout", rsp_valid, 1);
    repeat (10) tick();
    check("bp_no_grant", gq.size(), 1);
    check("bp_still_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    wait_idle(60);
    check("bp_both_served", gq.size(), 2);
    // A == B == all twos
    set_req(1, twos, twos);
    wait_idle(30);
    for (int e = 0; e < MAT_DIM * MAT_DIM; e++) check("twos_elem", last_rsp[e*ELEM_W +: ELEM_W], 16);
    // reset during WAIT
    set_req(1, rnd(), rnd());
    for (n = 0; n < 40 && !(busy_m && cyc >= acc_cyc + 3); n++) tick();
    check("wait_timeout", busy_m, 1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    gq.delete();
    repeat (4) tick();
    check("rst_no_rsp", rsp_valid, 0);
    set_req(0, rnd(), rnd());
    set_req(1, rnd(), rnd());
    wait_idle(60);
    check("rst_first_grant", gq.size() > 0 ? gq[0] : -1, 0);
    check("rst_second_grant", gq.size() > 1 ? gq[1] : -1, 1);
    check("rst_done", done_cnt, 2);
    // random traffic with random backpressure
    rnd_mode = 1;
    repeat (400) tick();
    rnd_mode  = 0;
    rsp_ready = 1'b1;
    wait_idle(100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
